uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each single-cycle `write_req`/`data` byte strobe from the receiver into a circular buffer of `BufferSize` entries. It presents the bytes to the CPU's memory-mapped UART register logic through a registered, one-cycle-latency read handshake. Full, empty, occupancy and a sticky overflow flag are exported for the status register and interrupt logic.

## Interface
Parameters:
- `BufferSize`, 128, number of byte entries; must be a power of two and ≥ 2 (elaboration-time assertion).
- `CntWidth`, `$clog2(BufferSize)+1`, width of `count`; derived, never overridden.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `write_req`  in  1  single-cycle strobe from the receiver: `data` is valid this cycle.
- `data`  in  8  received byte.
- `read_req`  in  1  CPU pop request; level-sampled each cycle.
- `read_data`  out  8  popped byte (registered).
- `read_valid`  out  1  one-cycle pulse: `read_data` holds a freshly popped byte.
- `empty`  out  1  high when occupancy is 0.
- `full`  out  1  high when occupancy is `BufferSize`.
- `count`  out  `CntWidth`  current occupancy, 0..`BufferSize`.
- `overflow`  out  1  sticky flag: a byte was dropped because the buffer was full.
- `clear_overflow`  in  1  clears `overflow`.

## Operation
- Storage is `BufferSize` x 8 memory with write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(BufferSize)` bits.
  - Pointers wrap modulo `BufferSize` by natural overflow.
  - Occupancy is held in a separate `count` register. Pointer equality is never used to tell full from empty.
- Push: occurs when `write_req && (!full || pop)`.
  - Writes `data` to `mem[wr_ptr]` and increments `wr_ptr`.
- Pop: occurs when `read_req && !empty`.
  - Loads `read_data <= mem[rd_ptr]`, increments `rd_ptr` and sets `read_valid`.
- `read_req` while `empty` is ignored:
  - no pointer change;
  - `read_valid` stays 0;
  - `read_data` is held.
- There is no fall-through. A byte pushed in cycle N cannot be popped in cycle N.
  - `empty` is evaluated on the registered count, before the push.
- Count update:
  - +1 for push only;
  - −1 for pop only;
  - unchanged for both or neither.
- Push and pop in the same cycle with `count == BufferSize`: both succeed and no overflow is recorded.
  - The slot being read and the slot being written coincide in that case. The read returns the old contents because the memory read is taken before the write lands.
- Dropped write: `write_req && full && !pop`.
  - The byte is discarded and no state other than `overflow` changes.
  - `overflow` is set on the next edge.
- `overflow` priority: a set in the same cycle as `clear_overflow` wins, so the flag stays 1.
- `read_data` is held between pops. It is never cleared except by reset.
- Reset: a synchronous reset mid-operation discards all contents on that edge.
  - Any concurrent `write_req`/`read_req` is ignored.
  - Memory contents are not reset; they are unreachable once the pointers are zeroed.

## Timing
- Reset values:
  - `read_data = 8'h00`;
  - `read_valid = 0`;
  - `empty = 1`;
  - `full = 0`;
  - `count = 0`;
  - `overflow = 0`.
  - Internally, `wr_ptr = rd_ptr = 0`.
- `empty`, `full` and `count` are registered. They reflect a push or pop on the cycle after the strobe.
- Read latency is 1 cycle: with `read_req` high in cycle N and `empty` low, `read_valid` and `read_data` are valid in cycle N+1.
- Back-to-back `read_req` pops one byte per cycle until `empty`. The consumer must sample `empty` each cycle and not over-issue.
- Write acceptance is 1 byte per cycle. The receiver strobes at most once per frame, so no backpressure is offered.
- `overflow` rises 1 cycle after the dropped strobe. `clear_overflow` takes effect on the next edge.

## Test plan
- Reset then single byte:
  - Stimulus: hold `rst_n=0` for 2 cycles, then push `8'hA5`, then `read_req` 1 cycle.
  - Response: after reset `empty=1`, `count=0`. After the push `count=1`. The cycle after `read_req` gives `read_valid=1`, `read_data=8'hA5`, and `empty=1` again.
- Fill and wrap:
  - Stimulus: push bytes 0..127 with `BufferSize=128`, pop 64, push 64 more (values 128..191), then drain.
  - Response: `full=1` at count 128, with no overflow. The drained sequence is 0..191 in order with no gaps.
- Overflow:
  - Stimulus: fill 128, push `8'hFF`, then pulse `clear_overflow`.
  - Response: `overflow` goes to 1 the next cycle and `count` stays 128. A drain returns the original 128 bytes with no `8'hFF`. `overflow` returns to 0 after the clear.
- Simultaneous events:
  - At `count=128`, push and pop in the same cycle: response is `count=128`, `overflow=0`, and the popped value is the oldest byte.
  - At `count=0`, push and `read_req` in the same cycle: `read_valid` stays 0 and `count=1`.
  - Set/clear collision: `clear_overflow` in the same cycle as a dropped write leaves `overflow=1`.
- Empty read and mid-operation reset:
  - Stimulus: `read_req` while empty, with `read_data` holding a prior value. Then, holding 5 bytes, assert `rst_n=0` for 1 cycle together with `write_req`.
  - Response: the empty read gives no `read_valid` and `read_data` unchanged. The reset gives all outputs at reset values on the next cycle and `count=0`.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer between the UART receiver and the CPU register
// interface. Bytes strobed in by the receiver are stored in a circular buffer
// and handed to the CPU through a registered one-cycle-latency pop.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   write_req      single-cycle strobe, data is valid this cycle
//   data           received byte
//   read_req       CPU pop request, level-sampled every cycle
//   read_data      popped byte (registered, held between pops)
//   read_valid     one-cycle pulse, read_data holds a freshly popped byte
//   empty          occupancy is 0 (registered)
//   full           occupancy is BufferSize (registered)
//   count          current occupancy, 0..BufferSize (registered)
//   overflow       sticky, a byte was dropped because the buffer was full
//   clear_overflow clears overflow (a simultaneous drop wins)
module uart_rx_fifo #(
    parameter int BufferSize = 128,
    parameter int CntWidth   = $clog2(BufferSize) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_req,
    input  logic [7:0]          data,
    input  logic                read_req,
    output logic [7:0]          read_data,
    output logic                read_valid,
    output logic                empty,
    output logic                full,
    output logic [CntWidth-1:0] count,
    output logic                overflow,
    input  logic                clear_overflow
);

    localparam int PtrWidth = $clog2(BufferSize);

    generate
        if (BufferSize < 2 || (BufferSize & (BufferSize - 1)) != 0) begin : g_bad_size
            $error("uart_rx_fifo: BufferSize must be a power of two and >= 2");
        end
    endgenerate

    logic [7:0]          mem [BufferSize];

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          read_data_q, read_data_d;
    logic                read_valid_q, read_valid_d;

    logic                push;
    logic                pop;
    logic                drop;

    always_comb begin
        // empty/full come from the registered count, so a byte pushed this
        // cycle cannot be popped this cycle, and a pop frees room for a push
        // into a full buffer.
        pop  = read_req && !empty_q;
        push = write_req && (!full_q || pop);
        drop = write_req && full_q && !pop;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        overflow_d   = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        end

        // Memory is read here, before the write lands at the edge, so a
        // push/pop on the same slot of a full buffer returns the old byte.
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PtrWidth'(1);
            read_data_d  = mem[rd_ptr_q];
            read_valid_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CntWidth'(BufferSize));

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            read_data_q  <= 8'h00;
            read_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once the
    // pointers are zeroed.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_q] <= data;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int BS = 128;
    localparam int CW = $clog2(BS) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_req = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          read_req = 1'b0;
    logic [7:0]    read_data;
    logic          read_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          clear_overflow = 1'b0;

    int            errors = 0;
    int            checks = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    exp_b;

    uart_rx_fifo #(.BufferSize(BS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .write_req(write_req),
        .data(data),
        .read_req(read_req),
        .read_data(read_data),
        .read_valid(read_valid),
        .empty(empty),
        .full(full),
        .count(count),
        .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    // Advance one active edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data got=%0h exp=00", read_data); end
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL reset_read_valid got=%0b exp=0", read_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single_byte();
        write_req = 1'b1; data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        write_req = 1'b0;
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_not_empty got=%0b exp=0", empty); end
        read_req = 1'b1;
        step();
        read_req = 1'b0;
        exp_b = exp_q.pop_front();
        checks++; if (read_valid !== 1'b1 || read_data !== exp_b) begin errors++; $display("FAIL single_pop got=%0b/%0h exp=1/%0h", read_valid, read_data, exp_b); end
        checks++; if (empty !== 1'b1 || count !== CW'(0)) begin errors++; $display("FAIL single_empty_again got=%0b/%0d exp=1/0", empty, count); end
        step();
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse got=%0b exp=0", read_valid); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < BS; i++) begin
            write_req = 1'b1; data = 8'(i); exp_q.push_back(8'(i));
            step();
        end
        write_req = 1'b0;
        checks++; if (full !== 1'b1 || count !== CW'(BS)) begin errors++; $display("FAIL fill_full got=%0b/%0d exp=1/%0d", full, count, BS); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow got=%0b exp=0", overflow); end
        read_req = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            exp_b = exp_q.pop_front();
            checks++; if (read_valid !== 1'b1 || read_data !== exp_b) begin errors++; $display("FAIL wrap_pop1 got=%0b/%0h exp=1/%0h", read_valid, read_data, exp_b); end
        end
        read_req = 1'b0;
        for (int i = 128; i < 192; i++) begin
            write_req = 1'b1; data = 8'(i); exp_q.push_back(8'(i));
            step();
        end
        write_req = 1'b0;
        checks++; if (full !== 1'b1 || count !== CW'(BS)) begin errors++; $display("FAIL wrap_full got=%0b/%0d exp=1/%0d", full, count, BS); end
        read_req = 1'b1;
        for (int k = 0; k < 2 * BS && exp_q.size() > 0; k++) begin
            step();
            exp_b = exp_q.pop_front();
            checks++; if (read_valid !== 1'b1 || read_data !== exp_b) begin errors++; $display("FAIL wrap_drain got=%0b/%0h exp=1/%0h", read_valid, read_data, exp_b); end
        end
        read_req = 1'b0;
        checks++; if (empty !== 1'b1 || count !== CW'(0)) begin errors++; $display("FAIL wrap_drained got=%0b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < BS; i++) begin
            write_req = 1'b1; data = 8'(i) ^ 8'h5A; exp_q.push_back(8'(i) ^ 8'h5A);
            step();
        end
        write_req = 1'b1; data = 8'hFF;
        step();
        write_req = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        checks++; if (count !== CW'(BS) || full !== 1'b1) begin errors++; $display("FAIL ovf_count got=%0d/%0b exp=%0d/1", count, full, BS); end
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
        read_req = 1'b1;
        for (int k = 0; k < 2 * BS && exp_q.size() > 0; k++) begin
            step();
            exp_b = exp_q.pop_front();
            checks++; if (read_valid !== 1'b1 || read_data !== exp_b) begin errors++; $display("FAIL ovf_drain got=%0b/%0h exp=1/%0h", read_valid, read_data, exp_b); end
        end
        read_req = 1'b0;
        checks++; if (empty !== 1'b1 || count !== CW'(0)) begin errors++; $display("FAIL ovf_drained got=%0b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < BS; i++) begin
            write_req = 1'b1; data = 8'(i + 3); exp_q.push_back(8'(i + 3));
            step();
        end
        // Push and pop together on a full buffer.
        write_req = 1'b1; data = 8'hC3; read_req = 1'b1;
        exp_b = exp_q.pop_front();
        exp_q.push_back(8'hC3);
        step();
        write_req = 1'b0; read_req = 1'b0;
        checks++; if (read_valid !== 1'b1 || read_data !== exp_b) begin errors++; $display("FAIL sim_full_pop got=%0b/%0h exp=1/%0h", read_valid, read_data, exp_b); end
        checks++; if (count !== CW'(BS) || overflow !== 1'b0) begin errors++; $display("FAIL sim_full_count got=%0d/%0b exp=%0d/0", count, overflow, BS); end
        // Dropped write colliding with clear_overflow.
        write_req = 1'b1; data = 8'h77; clear_overflow = 1'b1;
        step();
        write_req = 1'b0; clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b1 || count !== CW'(BS)) begin errors++; $display("FAIL sim_set_clear got=%0b/%0d exp=1/%0d", overflow, count, BS); end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_clear got=%0b exp=0", overflow); end
        read_req = 1'b1;
        for (int k = 0; k < 2 * BS && exp_q.size() > 0; k++) begin
            step();
            exp_b = exp_q.pop_front();
            checks++; if (read_valid !== 1'b1 || read_data !== exp_b) begin errors++; $display("FAIL sim_drain got=%0b/%0h exp=1/%0h", read_valid, read_data, exp_b); end
        end
        read_req = 1'b0;
        // Push and read_req together on an empty buffer: no fall-through.
        write_req = 1'b1; data = 8'h3C; read_req = 1'b1; exp_q.push_back(8'h3C);
        step();
        write_req = 1'b0;
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL sim_empty_no_valid got=%0b exp=0", read_valid); end
        checks++; if (count !== CW'(1) || empty !== 1'b0) begin errors++; $display("FAIL sim_empty_count got=%0d/%0b exp=1/0", count, empty); end
        step();
        read_req = 1'b0;
        exp_b = exp_q.pop_front();
        checks++; if (read_valid !== 1'b1 || read_data !== exp_b) begin errors++; $display("FAIL sim_empty_pop got=%0b/%0h exp=1/%0h", read_valid, read_data, exp_b); end
    endtask

    task automatic test_empty_read_and_reset();
        read_req = 1'b1;
        step();
        read_req = 1'b0;
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL empty_read_valid got=%0b exp=0", read_valid); end
        checks++; if (read_data !== 8'h3C) begin errors++; $display("FAIL empty_read_hold got=%0h exp=3c", read_data); end
        checks++; if (count !== CW'(0) || empty !== 1'b1) begin errors++; $display("FAIL empty_read_count got=%0d/%0b exp=0/1", count, empty); end
        for (int i = 0; i < 5; i++) begin
            write_req = 1'b1; data = 8'(8'h10 + i);
            step();
        end
        write_req = 1'b0;
        checks++; if (count !== CW'(5)) begin errors++; $display("FAIL rst_pre_count got=%0d exp=5", count); end
        rst_n = 1'b0; write_req = 1'b1; data = 8'hEE;
        step();
        rst_n = 1'b1; write_req = 1'b0;
        checks++; if (read_data !== 8'h00 || read_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_read got=%0h/%0b exp=00/0", read_data, read_valid); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%0b/%0b/%0b exp=1/0/0", empty, full, overflow); end
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
        write_req = 1'b1; data = 8'h42; exp_q.push_back(8'h42);
        step();
        write_req = 1'b0; read_req = 1'b1;
        step();
        read_req = 1'b0;
        exp_b = exp_q.pop_front();
        checks++; if (read_valid !== 1'b1 || read_data !== exp_b) begin errors++; $display("FAIL rst_after_pop got=%0b/%0h exp=1/%0h", read_valid, read_data, exp_b); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_after_empty got=%0b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_wrap();
        test_overflow();
        test_simultaneous();
        test_empty_read_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
